// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 exception unit for the single-cycle CPU.
// Holds Status (IE, IM), Cause (IP, ExcCode) and EPC. Latches rising edges on
// the external interrupt lines and redirects the PC combinationally for
// syscall entry, interrupt entry and eret.
module cp0_exception_unit #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0800,
  parameter int          NIRQ     = 3
) (
  input  logic            in_clk,
  input  logic            in_rst_n,
  input  logic            in_valid,
  input  logic            in_syscall,
  input  logic            in_mfc0,
  input  logic            in_mtc0,
  input  logic            in_eret,
  input  logic [4:0]      in_rd,
  input  logic [31:0]     in_wdata,
  input  logic [31:0]     in_next_pc,
  input  logic [NIRQ-1:0] in_irq,
  output logic [31:0]     out_rdata,
  output logic            out_redirect,
  output logic [31:0]     out_target,
  output logic            out_ie,
  output logic [NIRQ-1:0] out_ip
);

  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;

  // Architectural state
  logic            ie;
  logic [NIRQ-1:0] im;
  logic [NIRQ-1:0] ip;
  logic [4:0]      exc_code;
  logic [31:0]     epc;
  logic [NIRQ-1:0] irq_prev;

  // Next-state values
  logic            ie_nxt;
  logic [NIRQ-1:0] im_nxt;
  logic [NIRQ-1:0] ip_nxt;
  logic [4:0]      exc_code_nxt;
  logic [31:0]     epc_nxt;

  logic [NIRQ-1:0] irq_edge;
  logic [NIRQ-1:0] pe;
  logic [31:0]     irq_offset;

  assign irq_edge = in_irq & ~irq_prev;
  assign pe       = ip & im;
  assign out_ie   = ie;
  assign out_ip   = ip;

  // Vector offset of the lowest-numbered pending, enabled interrupt
  always_comb begin
    irq_offset = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pe[i]) irq_offset = 32'(16 * (i + 1));
    end
  end

  // Event priority: syscall > eret > mtc0 > interrupt; computes redirect and next state
  always_comb begin
    // NOTE: every output of this block is given a default first so that no
    // path through the if/case tree leaves a value unassigned (no latches).
    ie_nxt       = ie;
    im_nxt       = im;
    ip_nxt       = ip | irq_edge;
    exc_code_nxt = exc_code;
    epc_nxt      = epc;
    out_redirect = 1'b0;
    out_target   = '0;
    if (in_valid) begin
      if (in_syscall) begin
        out_redirect = 1'b1;
        out_target   = VEC_BASE;
        epc_nxt      = in_next_pc;
        exc_code_nxt = EXC_SYSCALL;
        ie_nxt       = 1'b0;
      end else if (in_eret) begin
        out_redirect = 1'b1;
        out_target   = epc;
        ie_nxt       = 1'b1;
      end else if (in_mtc0) begin
        case (in_rd)
          REG_STATUS: begin
            ie_nxt = in_wdata[0];
            im_nxt = in_wdata[8 +: NIRQ];
          end
          // Writing 0 acknowledges; a new edge in the same cycle still sets
          REG_CAUSE: ip_nxt = (ip & in_wdata[8 +: NIRQ]) | irq_edge;
          REG_EPC:   epc_nxt = in_wdata;
          default:   ;
        endcase
      end else if (ie && (pe != '0)) begin
        out_redirect = 1'b1;
        out_target   = VEC_BASE + irq_offset;
        epc_nxt      = in_next_pc;
        exc_code_nxt = EXC_INT;
        ie_nxt       = 1'b0;
      end
    end
  end

  // mfc0 read port; sees pre-edge register values
  always_comb begin
    out_rdata = '0;
    if (in_mfc0) begin
      case (in_rd)
        REG_STATUS: out_rdata = {21'b0, im, 7'b0, ie};
        REG_CAUSE:  out_rdata = {21'b0, ip, 1'b0, exc_code, 2'b0};
        REG_EPC:    out_rdata = epc;
        default:    out_rdata = '0;
      endcase
    end
  end

  // State register; the IRQ edge detector runs every cycle regardless of in_valid
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      ie       <= 1'b0;
      im       <= '0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
      irq_prev <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      ie       <= ie_nxt;
      im       <= im_nxt;
      ip       <= ip_nxt;
      exc_code <= exc_code_nxt;
      epc      <= epc_nxt;
      irq_prev <= in_irq;
    end
  end

endmodule
